// File: rtl/mem_multi_nr1w_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_multi_nr1w_pkg : shared types, FSM encodings and helpers for the RAM file
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_multi_nr1w_pkg;

  typedef enum int {
    RD_LAT_ONE = 1,
    RD_LAT_TWO = 2
  } rd_lat_e;

  localparam logic [0:0] CLR_IDLE = 1'b0;
  localparam logic [0:0] CLR_RUN  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_multi_nr1w_rd_port.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_multi_nr1w_rd_port : one read port (range check, forward mux, pipeline)
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_multi_nr1w_rd_port
  import mem_multi_nr1w_pkg::*;
#(
  parameter int WIDTH  = 512,
  parameter int DEPTH  = 70,
  parameter int AW     = 7,
  parameter int RD_LAT = 1,
  parameter int FWD    = 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] mem_word,
  input  logic             wr_fire,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wbitmask,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);

  logic             in_range;
  logic             fwd_hit;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] s1_data_q;
  logic             s1_valid_q;

  assign in_range = int'(raddr) < DEPTH;
  // Forwarding only on a real address match of a write that actually lands.
  assign fwd_hit  = (FWD != 0) && wr_fire && (waddr == raddr);

  always_comb begin
    word = '0;
    if (in_range) begin
      word = fwd_hit ? ((mem_word & ~wbitmask) | (wdata & wbitmask)) : mem_word;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_en;
      if (rd_en) s1_data_q <= word;
    end
  end

  if (RD_LAT == int'(RD_LAT_TWO)) begin : g_lat2
    logic [WIDTH-1:0] s2_data_q;
    logic             s2_valid_q;

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= s1_data_q;
        s2_valid_q <= s1_valid_q;
      end
    end

    assign rdata  = s2_data_q;
    assign rvalid = s2_valid_q;
  end else begin : g_lat1
    assign rdata  = s1_data_q;
    assign rvalid = s1_valid_q;
  end

endmodule
`default_nettype wire

// File: rtl/mem_multi_nr1w.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_multi_nr1w : distributed-RAM file, 1 masked write port, NUM_RD read ports
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_multi_nr1w
  import mem_multi_nr1w_pkg::*;
#(
  parameter  int WIDTH  = 512,
  parameter  int DEPTH  = 70,
  parameter  int NUM_RD = 2,
  parameter  int MASK_W = 64,
  parameter  int RD_LAT = 1,
  parameter  int FWD    = 1,
  localparam int AW     = clog2(DEPTH),
  localparam int NG     = WIDTH / MASK_W
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    clear,
  output logic                    busy,
  input  logic                    wren,
  input  logic [AW-1:0]           waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [NG-1:0]           wmask,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*AW-1:0]    raddr,
  output logic [NUM_RD*WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]       rvalid
);

  (* ram_style = "distributed" *) logic [WIDTH-1:0] mem_q [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             cnt_last;
  logic             clr_we;
  logic             wr_fire;
  logic [WIDTH-1:0] bitmask;

  assign cnt_last = int'(cnt_q) == (DEPTH - 1);
  assign wr_fire  = wren && !busy && (int'(waddr) < DEPTH);

  // Clear sequencer: state register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequencer: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (clear) begin
          state_d = CLR_RUN;
          cnt_d   = '0;
        end
      end
      CLR_RUN: begin
        if (cnt_last) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // Clear sequencer: outputs
  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    if (state_q == CLR_RUN) begin
      busy   = 1'b1;
      clr_we = 1'b1;
    end
  end

  // Single write process: sequencer zero-fill has priority, external writes are blocked while busy.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int g = 0; g < NG; g++) begin
        if (wmask[g]) mem_q[waddr][g*MASK_W +: MASK_W] <= wdata[g*MASK_W +: MASK_W];
      end
    end
  end

  for (genvar g = 0; g < NG; g++) begin : g_bitmask
    assign bitmask[g*MASK_W +: MASK_W] = {MASK_W{wmask[g]}};
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_idx;

    assign rd_addr = raddr[p*AW +: AW];
    // Out-of-range addresses index word 0; the port masks the result to zero.
    assign rd_idx  = (int'(rd_addr) < DEPTH) ? rd_addr : '0;

    mem_multi_nr1w_rd_port #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .RD_LAT (RD_LAT),
      .FWD    (FWD)
    ) u_rd_port (
      .clock    (clock),
      .rst_n    (rst_n),
      .rd_en    (rd_en[p]),
      .raddr    (rd_addr),
      .mem_word (mem_q[rd_idx]),
      .wr_fire  (wr_fire),
      .waddr    (waddr),
      .wdata    (wdata),
      .wbitmask (bitmask),
      .rdata    (rdata[p*WIDTH +: WIDTH]),
      .rvalid   (rvalid[p])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_multi_nr1w.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_multi_nr1w : scoreboard bench, DUT A (4 ports, lat 2, fwd) + DUT B (1 port, lat 1, no fwd)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_multi_nr1w;

  localparam int WIDTH  = 64;
  localparam int MASK_W = 16;
  localparam int NG     = WIDTH / MASK_W;
  localparam int DEPTH  = 37;
  localparam int NUM_RD = 4;
  localparam int AW     = 6;
  localparam int NS     = NUM_RD + 1;

  logic                    clock = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    clear = 1'b0;
  logic                    wren  = 1'b0;
  logic [AW-1:0]           waddr = '0;
  logic [WIDTH-1:0]        wdata = '0;
  logic [NG-1:0]           wmask = '0;
  logic [NUM_RD-1:0]       rd_en = '0;
  logic [NUM_RD*AW-1:0]    raddr = '0;

  logic                    busy_a, busy_b;
  logic [NUM_RD*WIDTH-1:0] rdata_a;
  logic [NUM_RD-1:0]       rvalid_a;
  logic [WIDTH-1:0]        rdata_b;
  logic [0:0]              rvalid_b;

  mem_multi_nr1w #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .MASK_W(MASK_W), .RD_LAT(2), .FWD(1)
  ) u_dut_a (
    .clock(clock), .rst_n(rst_n), .clear(clear), .busy(busy_a), .wren(wren), .waddr(waddr),
    .wdata(wdata), .wmask(wmask), .rd_en(rd_en), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
  );

  mem_multi_nr1w #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(1), .MASK_W(MASK_W), .RD_LAT(1), .FWD(0)
  ) u_dut_b (
    .clock(clock), .rst_n(rst_n), .clear(clear), .busy(busy_b), .wren(wren), .waddr(waddr),
    .wdata(wdata), .wmask(wmask), .rd_en(rd_en[0:0]), .raddr(raddr[AW-1:0]), .rdata(rdata_b),
    .rvalid(rvalid_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               due;
  } exp_t;

  // Reference model: plain word array plus clear progress.
  logic [WIDTH-1:0] m [DEPTH];
  bit               m_busy = 1'b0;
  int               m_idx  = 0;

  exp_t             q [NS][$];
  logic [WIDTH-1:0] last_exp [NS];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] mrg(input logic [WIDTH-1:0] o, input logic [WIDTH-1:0] n,
                                           input logic [NG-1:0] mk);
    logic [WIDTH-1:0] r;
    r = o;
    for (int g = 0; g < NG; g++) if (mk[g]) r[g*MASK_W +: MASK_W] = n[g*MASK_W +: MASK_W];
    return r;
  endfunction

  // Predict reads for the coming edge, take the edge, then advance the model.
  task automatic tick();
    bit wfire;
    wfire = wren && !m_busy && (int'(waddr) < DEPTH);
    for (int p = 0; p < NS; p++) begin
      int               ap;
      bit               en;
      logic [WIDTH-1:0] e;
      ap = (p < NUM_RD) ? int'(raddr[p*AW +: AW]) : int'(raddr[AW-1:0]);
      en = (p < NUM_RD) ? rd_en[p] : rd_en[0];
      if (en) begin
        if (ap >= DEPTH) e = '0;
        else begin
          e = m[ap];
          if ((p < NUM_RD) && wfire && (ap == int'(waddr))) e = mrg(e, wdata, wmask);
        end
        q[p].push_back('{d: e, due: cyc + ((p < NUM_RD) ? 2 : 1)});
      end
    end
    @(posedge clock);
    if (m_busy) begin
      m[m_idx] = '0;
      m_idx++;
      if (m_idx == DEPTH) m_busy = 1'b0;
    end else if (clear) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end
    if (wfire) m[waddr] = mrg(m[waddr], wdata, wmask);
    #1;
  endtask

  task automatic idle();
    wren  = 1'b0;
    clear = 1'b0;
    rd_en = '0;
  endtask

  task automatic enter_reset();
    idle();
    rst_n  = 1'b0;
    m_busy = 1'b0;
    m_idx  = 0;
    for (int p = 0; p < NS; p++) begin
      q[p].delete();
      last_exp[p] = '0;
    end
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d, input logic [NG-1:0] mk);
    wren  = 1'b1;
    waddr = AW'(a);
    wdata = d;
    wmask = mk;
  endtask

  task automatic rd(input int p, input int a);
    rd_en[p]            = 1'b1;
    raddr[p*AW +: AW]   = AW'(a);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a += NUM_RD) begin
      idle();
      for (int p = 0; p < NUM_RD; p++) rd(p, a + p);
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic fill(input logic [WIDTH-1:0] d);
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      wr(a, d, '1);
      tick();
    end
    idle();
  endtask

  task automatic clear_and_count();
    int n;
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (busy_a && n < 200) begin
      // External writes during the sweep must be dropped.
      wren  = $urandom_range(0, 1) == 1;
      waddr = AW'($urandom_range(0, DEPTH - 1));
      wdata = {$urandom, $urandom};
      wmask = '1;
      clear = $urandom_range(0, 3) == 0;
      n++;
      tick();
    end
    idle();
    chk("busy_len", WIDTH'(n), WIDTH'(DEPTH));
  endtask

  // Monitor: compares busy every cycle and pops the scoreboard when a port presents data.
  always @(negedge clock) begin : mon
    chk("busy_a", WIDTH'(busy_a), WIDTH'(m_busy));
    chk("busy_b", WIDTH'(busy_b), WIDTH'(m_busy));
    for (int p = 0; p < NS; p++) begin
      logic             v;
      logic [WIDTH-1:0] d;
      exp_t             e;
      v = (p < NUM_RD) ? rvalid_a[p] : rvalid_b[0];
      d = (p < NUM_RD) ? rdata_a[p*WIDTH +: WIDTH] : rdata_b;
      if (v) begin
        if (q[p].size() == 0) begin
          total++;
          bad++;
          $display("FAIL rvalid_unexpected[%0d]: got 1 required 0 (cycle %0d)", p, cyc);
        end else begin
          e = q[p].pop_front();
          chk($sformatf("rdata[%0d]", p), d, e.d);
          chk($sformatf("latency[%0d]", p), WIDTH'(cyc), WIDTH'(e.due));
          last_exp[p] = e.d;
        end
      end else begin
        chk($sformatf("rdata_hold[%0d]", p), d, last_exp[p]);
        if (q[p].size() != 0 && q[p][0].due <= cyc) begin
          total++;
          bad++;
          $display("FAIL rvalid_missing[%0d]: got 0 required 1 (cycle %0d)", p, cyc);
          e = q[p].pop_front();
          last_exp[p] = e.d;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int p = 0; p < NS; p++) last_exp[p] = '0;
    for (int a = 0; a < DEPTH; a++) m[a] = '0;
    enter_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Zero the uninitialised array; also checks the busy window length.
    clear_and_count();

    // Full-mask write then read on every port; out-of-range port reads zero.
    wr(5, {8{8'hA5}}, '1);
    tick();
    idle();
    rd(0, 5); rd(1, 5); rd(2, 40); rd(3, 5);
    tick();
    idle();
    repeat (3) tick();

    // Same-edge partial write with read of the same address.
    wr(9, '1, 4'b0011);
    rd(0, 9);
    tick();
    idle();
    repeat (3) tick();

    // Write to one address while another port reads a neighbour.
    wr(4, 64'h0123_4567_89AB_CDEF, '1);
    tick();
    wr(3, 64'hDEAD_BEEF_CAFE_F00D, '1);
    rd(0, 3); rd(1, 4); rd(2, 3); rd(3, 4);
    tick();
    idle();
    repeat (3) tick();

    // Boundary addresses across ports.
    wr(36, 64'h3636_3636_0000_FFFF, '1);
    tick();
    idle();
    rd(0, 0); rd(1, 36); rd(2, 37); rd(3, 36);
    tick();
    idle();
    rd(0, 36); rd(1, 63);
    tick();
    idle();
    repeat (3) tick();

    // Fill with ones, clear, verify the sweep and the result.
    fill('1);
    clear_and_count();
    read_all();

    // Reset in the middle of a clear: partial clear is retained.
    fill('1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int n = 0; n < 200 && !(m_busy && m_idx == 30); n++) begin
      rd(0, 2); rd(1, 35);
      tick();
      idle();
    end
    chk("clear_progress", WIDTH'(m_idx), WIDTH'(30));
    enter_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    read_all();

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      wren  = $urandom_range(0, 2) != 0;
      waddr = AW'($urandom_range(0, 45));
      wdata = {$urandom, $urandom};
      wmask = NG'($urandom);
      clear = $urandom_range(0, 150) == 0;
      for (int p = 0; p < NUM_RD; p++) begin
        rd_en[p]          = $urandom_range(0, 1) == 1;
        raddr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 40));
      end
      tick();
    end
    idle();
    repeat (6) tick();
    read_all();

    for (int p = 0; p < NS; p++) chk($sformatf("drain[%0d]", p), WIDTH'(q[p].size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
